// File: rtl/led_matrix_scanner_pkg.sv
// Shared definitions for the LED matrix scanner: register map, CTRL field
// positions and scan FSM state encoding.
package led_matrix_scanner_pkg;

    localparam logic [1:0] ADDR_FB     = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_IRQ    = 2'd3;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_BRIGHT_LSB = 1;
    localparam int unsigned CTRL_BRIGHT_MSB = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ON    = 2'd1,
        ST_BLANK = 2'd2
    } scan_state_t;

    function automatic logic [3:0] col_onehot(input logic [1:0] col);
        return 4'b0001 << col;
    endfunction

endpackage

// File: rtl/led_matrix_scanner_scan_timer.sv
// Down-counter timing the ON and BLANK phases; done is high in the last
// clock of a loaded interval (remaining == 0).
module led_matrix_scanner_scan_timer #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] remaining,
    output logic             done
);

    // Load a new interval length, otherwise count down and hold at zero
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            remaining <= '0;
        end else if (clear) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= load_value;
        end else if (remaining != '0) begin
            remaining <= remaining - WIDTH'(1);
        end
    end

    assign done = (remaining == '0);

endmodule

// File: rtl/led_matrix_scanner.sv
// Four-column, eight-row LED matrix scanner with CPU register interface,
// PWM brightness, inter-column blanking and a frame interrupt flag.
module led_matrix_scanner
    import led_matrix_scanner_pkg::*;
#(
    parameter int unsigned CPU_WIDTH   = 16,
    parameter int unsigned SCAN_LOG2   = 10,
    parameter int unsigned DEAD_CYCLES = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sel,
    input  logic [1:0]           addr,
    input  logic                 write,
    input  logic [CPU_WIDTH-1:0] wr_data,
    output logic [CPU_WIDTH-1:0] rd_data,
    output logic [7:0]           led_row,
    output logic [3:0]           led_column,
    output logic                 frame_tick
);

    localparam int unsigned DEAD_W = $clog2(DEAD_CYCLES + 1);
    localparam int unsigned TW     = (SCAN_LOG2 > DEAD_W) ? SCAN_LOG2 : DEAD_W;
    localparam logic [TW-1:0] ON_LOAD    = TW'((1 << SCAN_LOG2) - 1);
    localparam logic [TW-1:0] BLANK_LOAD = TW'(DEAD_CYCLES - 1);

    logic [7:0]  fb [4];
    logic [1:0]  last_col;
    logic        ctrl_en;
    logic [3:0]  ctrl_bright;
    logic        irq_flag;
    logic [7:0]  frame_cnt;
    scan_state_t state;
    logic [1:0]  column;
    logic [1:0]  next_column;

    logic          wr_fb;
    logic          wr_ctrl;
    logic          irq_clr;
    logic          tmr_load;
    logic [TW-1:0] tmr_value;
    logic [TW-1:0] tmr_remaining;
    logic          tmr_done;
    logic [TW-1:0] on_next;
    logic [3:0]    next_phase;
    logic          frame_wrap;
    logic          unused_bits;

    assign wr_fb   = sel && write && (addr == ADDR_FB);
    assign wr_ctrl = sel && write && (addr == ADDR_CTRL);
    assign irq_clr = sel && write && (addr == ADDR_IRQ) && wr_data[0];

    // Timer reload selection: full ON length from IDLE/BLANK, dead time after ON
    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = ON_LOAD;
        if (ctrl_en) begin
            case (state)
                ST_IDLE:  tmr_load = 1'b1;
                ST_ON: begin
                    tmr_load  = tmr_done;
                    tmr_value = BLANK_LOAD;
                end
                ST_BLANK: tmr_load = tmr_done;
                default:  tmr_load = 1'b0;
            endcase
        end
    end

    led_matrix_scanner_scan_timer #(
        .WIDTH (TW)
    ) u_scan_timer (
        .clock      (clock),
        .reset      (reset),
        .clear      (!ctrl_en),
        .load       (tmr_load),
        .load_value (tmr_value),
        .remaining  (tmr_remaining),
        .done       (tmr_done)
    );

    // The timer counts down from 2^SCAN_LOG2-1, so its complement is the ON
    // cycle index; +1 gives the index of the cycle the registered row feeds.
    assign on_next     = ~tmr_remaining + TW'(1);
    assign next_phase  = on_next[SCAN_LOG2-1 -: 4];
    assign next_column = column + 2'd1;
    assign frame_wrap  = ctrl_en && (state == ST_BLANK) && tmr_done && (column == 2'd3);
    assign unused_bits = ^{wr_data, on_next};

    // Frame buffer and last-written column for read-back
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                fb[i] <= '0;
            end
            last_col <= '0;
        end else if (wr_fb) begin
            fb[wr_data[9:8]] <= wr_data[7:0];
            last_col         <= wr_data[9:8];
        end
    end

    // CTRL register: enable and brightness
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctrl_en     <= 1'b0;
            ctrl_bright <= '0;
        end else if (wr_ctrl) begin
            ctrl_en     <= wr_data[CTRL_EN_BIT];
            ctrl_bright <= wr_data[CTRL_BRIGHT_MSB:CTRL_BRIGHT_LSB];
        end
    end

    // Frame interrupt flag; a set in the same cycle as a clear takes priority
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irq_flag <= 1'b0;
        end else if (frame_wrap) begin
            irq_flag <= 1'b1;
        end else if (irq_clr) begin
            irq_flag <= 1'b0;
        end
    end

    // Scan sequencer: state, column, frame counter and registered LED drive
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            column     <= '0;
            frame_cnt  <= '0;
            led_row    <= '0;
            led_column <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (!ctrl_en) begin
                state      <= ST_IDLE;
                column     <= '0;
                led_row    <= '0;
                led_column <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state      <= ST_ON;
                        column     <= '0;
                        led_column <= col_onehot(2'd0);
                        led_row    <= (ctrl_bright != 4'd0) ? fb[0] : '0;
                    end
                    ST_ON: begin
                        if (tmr_done) begin
                            state      <= ST_BLANK;
                            led_row    <= '0;
                            led_column <= '0;
                        end else begin
                            led_row <= (next_phase < ctrl_bright) ? fb[column] : '0;
                        end
                    end
                    ST_BLANK: begin
                        if (tmr_done) begin
                            state      <= ST_ON;
                            column     <= next_column;
                            led_column <= col_onehot(next_column);
                            led_row    <= (ctrl_bright != 4'd0) ? fb[next_column] : '0;
                            if (frame_wrap) begin
                                frame_tick <= 1'b1;
                                frame_cnt  <= frame_cnt + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state      <= ST_IDLE;
                        led_row    <= '0;
                        led_column <= '0;
                    end
                endcase
            end
        end
    end

    // Combinational register read-back, zero when not selected
    always_comb begin
        rd_data = '0;
        if (sel) begin
            case (addr)
                ADDR_FB:   rd_data[7:0] = fb[last_col];
                ADDR_CTRL: begin
                    rd_data[CTRL_EN_BIT]                     = ctrl_en;
                    rd_data[CTRL_BRIGHT_MSB:CTRL_BRIGHT_LSB] = ctrl_bright;
                end
                ADDR_STATUS: begin
                    rd_data[1:0]  = column;
                    rd_data[15:8] = frame_cnt;
                end
                ADDR_IRQ:  rd_data[0] = irq_flag;
                default:   rd_data = '0;
            endcase
        end
    end

endmodule

// File: doc/led_matrix_scanner.md
LED_MATRIX_SCANNER -- requirements
Module: led_matrix_scanner

Interface
REQ-001 SHALL have parameter CPU_WIDTH, default 16, CPU data bus width.
REQ-002 SHALL have parameter SCAN_LOG2, default 10, log2 of ON-phase length per column in clocks.
REQ-003 SHALL have parameter DEAD_CYCLES, default 16, blanking clocks between columns (>=1).
REQ-004 SHALL use one clock and an asynchronous, active-low reset; ports named clock and reset.
REQ-005 Ports:
 clock  in  1  system clock
 reset  in  1  async active-low reset
 sel  in  1  CPU I/O decode select for this block
 addr  in  2  register address
 write  in  1  CPU write strobe, qualified by sel
 wr_data  in  CPU_WIDTH  CPU write data
 rd_data  out  CPU_WIDTH  combinational read data, zero when sel=0
 led_row  out  8  active-high row drive
 led_column  out  4  one-hot active-high column drive
 frame_tick  out  1  one-clock pulse per completed frame

Function
REQ-006 Register map: addr0 FB write, wr_data[9:8]=column, [7:0]=row bits; addr1 CTRL, bit0=enable, bits[4:1]=brightness; addr2 STATUS (read-only), [1:0]=current column, [15:8]=frame count mod 256; addr3 IRQ, bit0=frame flag, write 1 to clear.
REQ-007 Reads: addr0 returns fb[last written column] zero-extended; addr1 returns CTRL zero-extended; unused bits read 0.
REQ-008 Frame buffer: 4 x 8-bit registers; write at edge t visible on led_row from edge t+1 when that column is in ON.
REQ-009 FSM states IDLE, ON, BLANK.
REQ-010 IDLE: led_row=0, led_column=0, column index=0; enable=1 -> ON, column 0, next edge.
REQ-011 ON: lasts exactly 2^SCAN_LOG2 clocks; led_column=one-hot(column); led_row=fb[column] when on_cnt[SCAN_LOG2-1:SCAN_LOG2-4] < brightness, else 0.
REQ-012 Brightness 0 -> led_row always 0 (column still driven); 15 -> rows on 15/16 of ON.
REQ-013 ON end -> BLANK; BLANK: led_row=0, led_column=0, exactly DEAD_CYCLES clocks.
REQ-014 BLANK end: column increments modulo 4 and state -> ON; on wrap 3->0 frame_tick pulses one clock, frame count increments (wraps 255->0), IRQ flag sets.
REQ-015 Simultaneous IRQ set and write-1-clear in same cycle: set wins.
REQ-016 enable cleared in any state: next edge -> IDLE, outputs zero, counters and column cleared, no frame_tick.
REQ-017 CTRL brightness change during ON takes effect next clock; FSM timing unaffected.
REQ-018 All outputs except rd_data registered; led_column never more than one bit set.

Reset
REQ-019 reset low: state IDLE, fb all 0, CTRL 0, IRQ 0, frame count 0, led_row 0, led_column 0, frame_tick 0, immediately and asynchronously.
REQ-020 Reset deassertion synchronous in effect; first FSM transition no earlier than first edge after release.
REQ-021 Reset mid-frame SHALL discard partial frame without frame_tick.

Structure
REQ-022 Shared package SHALL hold register address constants (FB, CTRL, STATUS, IRQ), CTRL bit positions, FSM state encoding.
REQ-023 One sub-module natural: scan_timer (ON/BLANK down-counter with done pulse); all else in top.

Verification
REQ-024 Reset, enable=1, brightness=15, fb={0x01,0x02,0x04,0x08} -> led_column 0001..1000 in sequence, led_row matches fb, ON 1024 clocks, BLANK 16 clocks both outputs 0.
REQ-025 Full frame -> frame_tick one pulse after column 3 BLANK, STATUS[15:8]=1, IRQ=1; write 1 to addr3 -> IRQ=0; clear coinciding with next tick -> IRQ stays 1.
REQ-026 brightness=4, fb[0]=0xFF -> led_row=0xFF exactly 256 clocks of 1024 ON, 0 otherwise; brightness=0 -> led_row always 0.
REQ-027 Disable mid-column 2 -> next clock outputs 0, STATUS[1:0]=0, no frame_tick; re-enable -> column 0 ON next edge.
REQ-028 Write fb[1]=0xA5 during column-1 ON -> led_row=0xA5 on next clock; sel=0 -> rd_data=0 and writes ignored.
REQ-029 Assert reset mid-BLANK of column 3 -> all outputs 0 immediately, no frame_tick, frame count 0.
